// File: rtl/id_branch_resolve_ctrl_if.sv
// Handshake and status bundle between the ID-stage branch sequencer and the pipeline around it.
// The slave modport is the sequencer's view. The master modport is the pipeline/fetch view.
interface id_branch_resolve_ctrl_if #(
  parameter int PERF_W = 16
);
  logic              id_br_valid;
  logic [4:0]        id_rs1;
  logic [4:0]        id_rs2;
  logic [4:0]        idex_rd;
  logic              idex_regwren;
  logic              idex_memread;
  logic [4:0]        exmem_rd;
  logic              exmem_regwren;
  logic              exmem_memread;
  logic              pred_taken;
  logic              cmp_taken;
  logic              redirect_ack;
  logic              stall;
  logic              bubble_idex;
  logic              flush_ifid;
  logic              redirect_valid;
  logic              redirect_taken;
  logic              bp_update;
  logic [PERF_W-1:0] stall_cnt;
  logic [PERF_W-1:0] mispred_cnt;

  modport slave (
    input  id_br_valid, id_rs1, id_rs2,
    input  idex_rd, idex_regwren, idex_memread,
    input  exmem_rd, exmem_regwren, exmem_memread,
    input  pred_taken, cmp_taken, redirect_ack,
    output stall, bubble_idex, flush_ifid,
    output redirect_valid, redirect_taken, bp_update,
    output stall_cnt, mispred_cnt
  );

  modport master (
    output id_br_valid, id_rs1, id_rs2,
    output idex_rd, idex_regwren, idex_memread,
    output exmem_rd, exmem_regwren, exmem_memread,
    output pred_taken, cmp_taken, redirect_ack,
    input  stall, bubble_idex, flush_ifid,
    input  redirect_valid, redirect_taken, bp_update,
    input  stall_cnt, mispred_cnt
  );
endinterface

// File: rtl/id_branch_resolve_ctrl.sv
// ID-stage branch sequencer: stalls until forwarded operands are ready, then resolves, updates the predictor and redirects fetch.
// Controls are combinational from state and inputs. A mispredict redirect is held, with IF/ID stalled and flushed, until fetch acks.
module id_branch_resolve_ctrl #(
  parameter int PERF_W     = 16,
  parameter int LOAD_STALL = 2
) (
  input logic                     clk,
  input logic                     rst_n,
  id_branch_resolve_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, STALL, RESOLVE, REDIRECT} state_t;

  localparam logic [1:0]        LOAD_N = LOAD_STALL[1:0];
  localparam logic [PERF_W-1:0] ONE    = PERF_W'(1);
  localparam logic [PERF_W-1:0] SAT    = '1;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              redir_taken_q, redir_taken_d;
  logic [PERF_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [PERF_W-1:0] mispred_cnt_q, mispred_cnt_d;

  logic       match_idex, match_exmem;
  logic [1:0] need;
  logic       do_resolve, mispred;
  logic       stall_o, bubble_o, flush_o, rvalid_o, rtaken_o, bp_o;

  always_comb begin
    match_idex  = bus.idex_regwren && (bus.idex_rd != 5'd0) &&
                  ((bus.idex_rd == bus.id_rs1) || (bus.idex_rd == bus.id_rs2));
    match_exmem = bus.exmem_regwren && (bus.exmem_rd != 5'd0) &&
                  ((bus.exmem_rd == bus.id_rs1) || (bus.exmem_rd == bus.id_rs2));
    if (match_idex && bus.idex_memread) begin
      need = LOAD_N;
    end else if (match_idex || (match_exmem && bus.exmem_memread)) begin
      need = 2'd1;
    end else begin
      need = 2'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_taken_d = redir_taken_q;
    do_resolve    = 1'b0;
    mispred       = 1'b0;
    stall_o       = 1'b0;
    bubble_o      = 1'b0;
    flush_o       = 1'b0;
    rvalid_o      = 1'b0;
    rtaken_o      = 1'b0;
    bp_o          = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.id_br_valid) begin
          if (need == 2'd0) begin
            do_resolve = 1'b1;
          end else begin
            stall_o  = 1'b1;
            bubble_o = 1'b1;
            cnt_d    = need - 2'd1;
            state_d  = (need == 2'd1) ? RESOLVE : STALL;
          end
        end
      end
      // cnt_q holds the stall cycles still owed, including this one.
      STALL: begin
        stall_o  = 1'b1;
        bubble_o = 1'b1;
        cnt_d    = cnt_q - 2'd1;
        if (cnt_q == 2'd1) begin
          state_d = RESOLVE;
        end
      end
      RESOLVE: begin
        do_resolve = 1'b1;
      end
      REDIRECT: begin
        stall_o  = 1'b1;
        flush_o  = 1'b1;
        rvalid_o = 1'b1;
        rtaken_o = redir_taken_q;
        if (bus.redirect_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (do_resolve) begin
      bp_o     = 1'b1;
      rtaken_o = bus.cmp_taken;
      state_d  = IDLE;
      if (bus.cmp_taken != bus.pred_taken) begin
        mispred       = 1'b1;
        flush_o       = 1'b1;
        rvalid_o      = 1'b1;
        redir_taken_d = bus.cmp_taken;
        if (!bus.redirect_ack) begin
          state_d = REDIRECT;
        end
      end
    end

    stall_cnt_d   = (stall_o && (stall_cnt_q != SAT)) ? stall_cnt_q + ONE : stall_cnt_q;
    mispred_cnt_d = (mispred && (mispred_cnt_q != SAT)) ? mispred_cnt_q + ONE : mispred_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      redir_taken_q <= 1'b0;
      stall_cnt_q   <= '0;
      mispred_cnt_q <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      redir_taken_q <= redir_taken_d;
      stall_cnt_q   <= stall_cnt_d;
      mispred_cnt_q <= mispred_cnt_d;
    end
  end

  assign bus.stall          = stall_o;
  assign bus.bubble_idex    = bubble_o;
  assign bus.flush_ifid     = flush_o;
  assign bus.redirect_valid = rvalid_o;
  assign bus.redirect_taken = rtaken_o;
  assign bus.bp_update      = bp_o;
  assign bus.stall_cnt      = stall_cnt_q;
  assign bus.mispred_cnt    = mispred_cnt_q;

endmodule
